// File: rtl/mdu_sequencer_if.sv
// +----------------------------------------------------------------------+
// | mdu_sequencer_if : issue/retire handshake bundle for the MDU         |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface mdu_sequencer_if #(
  parameter int ALU_OP_WIDTH = 5,
  parameter int DATA_WIDTH   = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [ALU_OP_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0]   oprand1;
  logic [DATA_WIDTH-1:0]   oprand2;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   result;
  logic                    busy;

  modport master (
    output in_valid, op, oprand1, oprand2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, oprand1, oprand2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

`default_nettype wire

// File: rtl/mdu_sequencer.sv
// +----------------------------------------------------------------------+
// | mdu_sequencer : multi-cycle multiply / radix-2 restoring divide unit |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mdu_sequencer #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_ITERS = 32
) (
  input wire          clk,
  input wire          rst,
  mdu_sequencer_if.slave mdu
);

  localparam logic [4:0] ALU_MUL   = 5'b00000;
  localparam logic [4:0] ALU_MULH  = 5'b00001;
  localparam logic [4:0] ALU_MULHU = 5'b10001;
  localparam logic [4:0] ALU_DIV   = 5'b00100;
  localparam logic [4:0] ALU_DIVU  = 5'b00101;
  localparam logic [4:0] ALU_MOD   = 5'b00110;
  localparam logic [4:0] ALU_MODU  = 5'b00111;

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);
  localparam logic [4:0] MUL_LAST  = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q;
  logic [4:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvsr_q;
  logic        q_neg_q, r_neg_q, rem_sel_q;
  logic [31:0] result_q, last_q;
  logic        out_valid_q, busy_q;

  // Input-side decode used only in the accept cycle
  logic        accept;
  logic        in_is_mul, in_is_div, in_signed, in_rem, div_zero, div_ovf;
  logic [31:0] special_res, abs1, abs2;

  assign accept    = mdu.in_valid && mdu.in_ready;
  assign in_is_mul = (mdu.op == ALU_MUL) || (mdu.op == ALU_MULH) || (mdu.op == ALU_MULHU);
  assign in_signed = (mdu.op == ALU_DIV) || (mdu.op == ALU_MOD);
  assign in_rem    = (mdu.op == ALU_MOD) || (mdu.op == ALU_MODU);
  assign in_is_div = in_signed || (mdu.op == ALU_DIVU) || (mdu.op == ALU_MODU);
  assign div_zero  = (mdu.oprand2 == 32'd0);
  assign div_ovf   = in_signed && (mdu.oprand1 == 32'h8000_0000) && (mdu.oprand2 == 32'hFFFF_FFFF);
  assign special_res = div_zero ? (in_rem ? mdu.oprand1 : 32'hFFFF_FFFF)
                                : (in_rem ? 32'd0 : 32'h8000_0000);
  assign abs1 = (in_signed && mdu.oprand1[31]) ? -mdu.oprand1 : mdu.oprand1;
  assign abs2 = (in_signed && mdu.oprand2[31]) ? -mdu.oprand2 : mdu.oprand2;

  // Multiplier reads live inputs only when MUL_LAT==1 finishes in the accept cycle
  logic [4:0]  mop;
  logic [31:0] ma, mb, mul_res;
  logic [63:0] ma_x, mb_x, prod;

  assign mop     = (state_q == S_IDLE) ? mdu.op : op_q;
  assign ma      = (state_q == S_IDLE) ? mdu.oprand1 : a_q;
  assign mb      = (state_q == S_IDLE) ? mdu.oprand2 : b_q;
  assign ma_x    = mop[4] ? {32'd0, ma} : {{32{ma[31]}}, ma};
  assign mb_x    = mop[4] ? {32'd0, mb} : {{32{mb[31]}}, mb};
  assign prod    = ma_x * mb_x;
  assign mul_res = (mop == ALU_MUL) ? prod[31:0] : prod[63:32];

  logic [32:0] rem_sh, diff;
  logic        ge;
  logic [31:0] rem_n, quo_n, div_res;

  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {1'b0, dvsr_q};
  assign ge      = ~diff[32];
  assign rem_n   = ge ? diff[31:0] : rem_sh[31:0];
  assign quo_n   = {quo_q[30:0], ge};
  assign div_res = rem_sel_q ? (r_neg_q ? -rem_n : rem_n)
                             : (q_neg_q ? -quo_n : quo_n);

  assign mdu.in_ready  = (state_q == S_IDLE) && !mdu.flush;
  assign mdu.out_valid = out_valid_q;
  assign mdu.result    = result_q;
  assign mdu.busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      cnt_q       <= 5'd0;
      rem_q       <= 32'd0;
      quo_q       <= 32'd0;
      dvsr_q      <= 32'd0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_sel_q   <= 1'b0;
      result_q    <= 32'd0;
      last_q      <= 32'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (mdu.flush) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      // A flushed result never retired, so fall back to the last retired one
      if (state_q == S_DONE) result_q <= last_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= mdu.op;
            a_q       <= mdu.oprand1;
            b_q       <= mdu.oprand2;
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            rem_q     <= 32'd0;
            quo_q     <= abs1;
            dvsr_q    <= abs2;
            q_neg_q   <= in_signed && (mdu.oprand1[31] ^ mdu.oprand2[31]);
            r_neg_q   <= in_signed && mdu.oprand1[31];
            rem_sel_q <= in_rem;
            if (in_is_mul) begin
              if (MUL_LAT == 1) begin
                state_q     <= S_DONE;
                result_q    <= mul_res;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= S_MUL;
              end
            end else if (in_is_div && !div_zero && !div_ovf) begin
              state_q <= S_DIV;
            end else begin
              state_q     <= S_DONE;
              result_q    <= in_is_div ? special_res : 32'd0;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_q     <= S_DONE;
            result_q    <= mul_res;
            out_valid_q <= 1'b1;
            cnt_q       <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          if (cnt_q == LAST_ITER) begin
            state_q     <= S_DONE;
            result_q    <= div_res;
            out_valid_q <= 1'b1;
            cnt_q       <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          if (mdu.out_ready) begin
            state_q     <= S_IDLE;
            last_q      <= result_q;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_mdu_sequencer : directed self-checking bench for mdu_sequencer    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mdu_sequencer;

  localparam logic [4:0] ALU_MUL   = 5'b00000;
  localparam logic [4:0] ALU_MULH  = 5'b00001;
  localparam logic [4:0] ALU_MULHU = 5'b10001;
  localparam logic [4:0] ALU_DIV   = 5'b00100;
  localparam logic [4:0] ALU_DIVU  = 5'b00101;
  localparam logic [4:0] ALU_MOD   = 5'b00110;
  localparam logic [4:0] ALU_MODU  = 5'b00111;
  localparam logic [4:0] ALU_BAD   = 5'b01010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mdu_sequencer_if bus ();

  mdu_sequencer #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op (caller is just past a rising edge), then wait for out_valid
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.oprand1  = a;
    bus.oprand2  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = ALU_MULHU;
    bus.oprand1  = 32'hDEAD_BEEF;
    bus.oprand2  = 32'h0000_0001;
    check({tag, ".busy"}, {63'd0, bus.busy}, 64'd1);
    n = 1;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_lat));
    check({tag, ".result"}, {32'd0, bus.result}, {32'd0, exp_res});
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".retired"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int  stable;
    logic seen;
    bus.in_valid  = 1'b0;
    bus.op        = ALU_MUL;
    bus.oprand1   = 32'd0;
    bus.oprand2   = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    check("reset.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset.busy",      {63'd0, bus.busy},      64'd0);
    check("reset.result",    {32'd0, bus.result},    64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset.in_ready", {63'd0, bus.in_ready}, 64'd1);

    run_op("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 33, 32'h0000_000E);   retire("divu_100_7");
    run_op("modu_100_7", ALU_MODU, 32'd100, 32'd7, 33, 32'h0000_0002);   retire("modu_100_7");
    run_op("div_m7_2",   ALU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD); retire("div_m7_2");
    run_op("mod_m7_2",   ALU_MOD, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF); retire("mod_m7_2");
    run_op("div_7_m2",   ALU_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD); retire("div_7_m2");
    run_op("mod_7_m2",   ALU_MOD, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001); retire("mod_7_m2");
    run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000); retire("div_ovf");
    run_op("mod_ovf", ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000); retire("mod_ovf");
    run_op("mulh_m1",  ALU_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000); retire("mulh_m1");
    run_op("mulhu_m1", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE); retire("mulhu_m1");
    run_op("mul_m1",   ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0001); retire("mul_m1");
    run_op("mul_7_m3",  ALU_MUL,   32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB); retire("mul_7_m3");
    run_op("mulh_7_m3", ALU_MULH,  32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFF); retire("mulh_7_m3");
    run_op("mulhu_2p31", ALU_MULHU, 32'h8000_0000, 32'd2, 2, 32'h0000_0001); retire("mulhu_2p31");
    run_op("bad_op",   ALU_BAD, 32'd12, 32'd34, 1, 32'h0000_0000);      retire("bad_op");
    run_op("divu_5_0", ALU_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);       retire("divu_5_0");

    // Hold a result with the consumer stalled
    bus.out_ready = 1'b0;
    run_op("modu_5_0", ALU_MODU, 32'd5, 32'd0, 1, 32'h0000_0005);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid && !bus.in_ready && bus.result == 32'h0000_0005) stable++;
    end
    check("modu_5_0.hold", 64'(stable), 64'd10);
    retire("modu_5_0");

    // Flush a divide at iteration 10; last retired value is 5
    bus.in_valid = 1'b1;
    bus.op       = ALU_DIV;
    bus.oprand1  = 32'd1000;
    bus.oprand2  = 32'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush.busy",      {63'd0, bus.busy},      64'd0);
    check("flush.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("flush.in_ready_during", {63'd0, bus.in_ready}, 64'd0);
    bus.flush = 1'b0;
    #1;
    check("flush.in_ready_after", {63'd0, bus.in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush.no_out_valid", {63'd0, seen}, 64'd0);
    check("flush.result_kept", {32'd0, bus.result}, 64'h5);

    // Reset in the middle of a multiply
    bus.in_valid = 1'b1;
    bus.op       = ALU_MUL;
    bus.oprand1  = 32'd6;
    bus.oprand2  = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mul.out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_mul.busy",      {63'd0, bus.busy},      64'd0);
    check("rst_mul.result",    {32'd0, bus.result},    64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mul.in_ready", {63'd0, bus.in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_mul.no_out_valid", {63'd0, seen}, 64'd0);
    run_op("divu_9_3", ALU_DIVU, 32'd9, 32'd3, 33, 32'h0000_0003); retire("divu_9_3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
